// File: rtl/coa_pkg.sv
// Shared types and constants for the serial shifter TX block.
// SERIAL_SHIFTER_TX_PARITY_EN adds one even-parity bit to every frame.
package coa_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

  localparam int DEFAULT_WIDTH = 32;

  // Bits on the wire per word: the data bits, plus parity when it is enabled.
  function automatic int frame_bits(int width);
`ifdef SERIAL_SHIFTER_TX_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction
endpackage

// File: rtl/serial_shifter_tx_if.sv
// Parallel-load / serial-out handshake bundle of serial_shifter_tx.
interface serial_shifter_tx_if #(parameter int WIDTH = coa_pkg::DEFAULT_WIDTH);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic             ser_valid;
  logic             ser_ready;
  logic             ser_out;
  logic             done;

  modport master (output load_valid, load_data, ser_ready,
                  input  load_ready, ser_valid, ser_out, done);
  modport slave  (input  load_valid, load_data, ser_ready,
                  output load_ready, ser_valid, ser_out, done);
endinterface

// File: rtl/serial_shifter_tx_bit_counter.sv
// Saturating bit index 0..MAX for serial_shifter_tx; never wraps past MAX.
module bit_counter #(
  parameter int MAX = 31,
  parameter int CW  = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          enable,
  output logic [CW-1:0] count,
  output logic          last
);
  assign last = (count == CW'(MAX));

  always_ff @(posedge clk) begin
    if (!rst || clear)        count <= '0;
    else if (enable && !last) count <= count + 1'b1;
  end
endmodule

// File: rtl/serial_shifter_tx.sv
// Parallel-to-serial transmitter, MSB first, valid/ready on both sides.
// SERIAL_SHIFTER_TX_PARITY_EN appends an even-parity bit after data bit 0.
module serial_shifter_tx
  import coa_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic            clk,
  input logic            rst,
  serial_shifter_tx_if.slave bus
);
  localparam int NB = frame_bits(WIDTH);
  localparam int CW = $clog2(NB);

  state_t          state, nstate;
  logic [NB-1:0]   frame, sreg;
  logic [CW-1:0]   cnt, idx;
  logic            last, load_fire, bit_fire;

`ifdef SERIAL_SHIFTER_TX_PARITY_EN
  assign frame = {bus.load_data, ^bus.load_data};
`else
  assign frame = bus.load_data;
`endif

  assign load_fire = (state == IDLE)  && bus.load_valid;
  assign bit_fire  = (state == SHIFT) && bus.ser_ready;
  assign idx       = CW'(NB - 1) - cnt;

  // The word stays parked in sreg; the counter walks the index down from the MSB.
  always_ff @(posedge clk) begin
    if (!rst)           sreg <= '0;
    else if (load_fire) sreg <= frame;
  end

  bit_counter #(.MAX(NB - 1), .CW(CW)) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .clear  (state != SHIFT),
    .enable (bit_fire),
    .count  (cnt),
    .last   (last)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (load_fire) nstate = SHIFT;
      SHIFT:   if (bit_fire && last) nstate = DONE;
      DONE:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // Outputs decode only flops (state, sreg, counter), so no input or rst reaches them.
  always_comb begin
    bus.load_ready = (state == IDLE);
    bus.ser_valid  = (state == SHIFT);
    bus.ser_out    = (state == SHIFT) && sreg[idx];
    bus.done       = (state == DONE);
  end
endmodule

// File: tb/tb_serial_shifter_tx.sv
// Bench for serial_shifter_tx (WIDTH=8): per-cycle model compare plus directed streams.
module tb_serial_shifter_tx;
  localparam int W = 8;
`ifdef SERIAL_SHIFTER_TX_PARITY_EN
  localparam int NB  = W + 1;
  localparam bit PAR = 1'b1;
`else
  localparam int NB  = W;
  localparam bit PAR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  serial_shifter_tx_if #(.WIDTH(W)) bus();
  serial_shifter_tx #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int errors = 0, checks = 0, cyc = 0, done_n = 0, done_cyc = 0;
  int m_idx = -1;              // -1 idle, 0..NB-1 presenting bit m_idx, NB done
  logic [W-1:0] m_word = '0;
  logic got[$];
  int ld_cyc[$];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic exp_bit(int i);
    if (i < W) return m_word[W-1-i];
    return ^m_word;
  endfunction

  function automatic logic [63:0] fr(logic [7:0] v, logic p);
    if (PAR) return {55'b0, v, p};
    return {56'b0, v};
  endfunction

  function automatic logic [63:0] pack(int from);
    logic [63:0] r = '0;
    for (int i = 0; i < NB; i++)
      r = {r[62:0], (from + i < got.size()) ? got[from + i] : 1'b0};
    return r;
  endfunction

  // One clock: advance the model from the inputs at the edge, then compare every output.
  task automatic tick();
    logic acc, b;
    acc = bus.ser_valid && bus.ser_ready && rst;
    b   = bus.ser_out;
    @(posedge clk);
    cyc++;
    if (acc) got.push_back(b);
    if (!rst) m_idx = -1;
    else if (m_idx < 0) begin
      if (bus.load_valid) begin m_word = bus.load_data; m_idx = 0; ld_cyc.push_back(cyc); end
    end
    else if (m_idx < NB) begin
      if (bus.ser_ready) m_idx++;
    end
    else m_idx = -1;
    #1;
    chk("load_ready", bus.load_ready, m_idx < 0);
    chk("ser_valid", bus.ser_valid, (m_idx >= 0 && m_idx < NB));
    chk("ser_out", bus.ser_out, (m_idx >= 0 && m_idx < NB) ? exp_bit(m_idx) : 1'b0);
    chk("done", bus.done, m_idx == NB);
    if (bus.done) begin done_n++; done_cyc = cyc; end
  endtask

  task automatic wait_done(int d0);
    for (int k = 0; k < 80 && done_n == d0; k++) tick();
    chk("done_seen", done_n, d0 + 1);
  endtask

  task automatic start(logic [7:0] v);
    got.delete(); ld_cyc.delete();
    bus.load_valid = 1'b1; bus.load_data = v;
    tick();
    bus.load_valid = 1'b0;
  endtask

  initial begin
    int d0;
    bus.load_valid = 1'b0; bus.load_data = '0; bus.ser_ready = 1'b0;
    repeat (2) tick();
    chk("reset_load_ready", bus.load_ready, 1'b1);
    chk("reset_ser_valid", bus.ser_valid, 1'b0);
    rst = 1'b1;
    tick();

    // A5, ready always high
    bus.ser_ready = 1'b1;
    d0 = done_n;
    start(8'hA5);
    wait_done(d0);
    chk("a5_stream", pack(0), fr(8'hA5, 1'b0));
    chk("a5_done_lat", done_cyc - ld_cyc[0], NB);
    tick();

    // F0, ready toggling
    d0 = done_n;
    start(8'hF0);
    for (int k = 0; k < 80 && done_n == d0; k++) begin
      bus.ser_ready = ~bus.ser_ready;
      tick();
    end
    chk("f0_done", done_n, d0 + 1);
    chk("f0_stream", pack(0), fr(8'hF0, 1'b0));
    bus.ser_ready = 1'b1;
    tick();

    // 3C aborted by reset after the third bit, then 81
    d0 = done_n;
    start(8'h3C);
    for (int k = 0; k < 20 && got.size() < 3; k++) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("abort_load_ready", bus.load_ready, 1'b1);
    chk("abort_ser_valid", bus.ser_valid, 1'b0);
    repeat (NB + 2) tick();
    chk("abort_no_done", done_n, d0);
    start(8'h81);
    wait_done(d0);
    chk("81_stream", pack(0), fr(8'h81, 1'b0));
    tick();

    // load_valid held through SHIFT: 11 then 22
    d0 = done_n;
    got.delete(); ld_cyc.delete();
    bus.load_valid = 1'b1; bus.load_data = 8'h11;
    tick();
    bus.load_data = 8'h22;
    for (int k = 0; k < 80 && ld_cyc.size() < 2; k++) tick();
    bus.load_valid = 1'b0;
    wait_done(d0 + 1);
    chk("hold_two_loads", ld_cyc.size(), 2);
    chk("hold_period", ld_cyc[1] - ld_cyc[0], NB + 2);
    chk("11_stream", pack(0), fr(8'h11, 1'b0));
    chk("22_stream", pack(NB), fr(8'h22, 1'b0));
    tick();

    // back-to-back 55 then AA
    d0 = done_n;
    got.delete(); ld_cyc.delete();
    bus.load_valid = 1'b1; bus.load_data = 8'h55;
    tick();
    bus.load_data = 8'hAA;
    for (int k = 0; k < 80 && ld_cyc.size() < 2; k++) tick();
    bus.load_valid = 1'b0;
    wait_done(d0 + 1);
    chk("b2b_gap", ld_cyc[1] - ld_cyc[0], NB + 2);
    chk("55_stream", pack(0), fr(8'h55, 1'b0));
    chk("aa_stream", pack(NB), fr(8'hAA, 1'b0));
    tick();

`ifdef SERIAL_SHIFTER_TX_PARITY_EN
    d0 = done_n;
    start(8'h07);
    wait_done(d0);
    chk("07_parity_stream", pack(0), 64'h00F);
    tick();
    start(8'h03);
    wait_done(d0 + 1);
    chk("03_parity_stream", pack(0), 64'h006);
    tick();
`endif

    // randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      bus.load_valid = 1'($urandom_range(0, 1));
      bus.load_data  = 8'($urandom);
      bus.ser_ready  = ($urandom_range(0, 3) != 0);
      rst            = ($urandom_range(0, 149) != 0);
      tick();
    end
    rst = 1'b1;
    bus.load_valid = 1'b0;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/serial_shifter_tx.md
SERIAL_SHIFTER_TX -- requirements
Module: serial_shifter_tx

Interface
REQ-001 Parameter WIDTH, default 32, number of data bits per word; legal range 2..64.
REQ-002 clk  input  1  sole clock; all state changes on posedge clk.
REQ-003 rst  input  1  reset, synchronous and active-low; sampled only at posedge clk; rst==0 resets.
REQ-004 load_valid  input  1  producer offers load_data this cycle.
REQ-005 load_data  input  WIDTH  parallel word to serialize.
REQ-006 load_ready  output  1  block can accept a word; high only in IDLE.
REQ-007 ser_ready  input  1  consumer accepts the current serial bit this cycle.
REQ-008 ser_valid  output  1  ser_out holds a valid bit.
REQ-009 ser_out  output  1  current serial bit, MSB first.
REQ-010 done  output  1  one-cycle pulse after the last bit is accepted.

Function
REQ-011 FSM states SHALL be IDLE, SHIFT and DONE only.
REQ-012 IDLE: load_ready=1, ser_valid=0, ser_out=0, done=0.
REQ-013 Load handshake SHALL complete when load_valid && load_ready at posedge clk; the word is captured and the state goes to SHIFT.
REQ-014 Load-to-first-bit latency SHALL be 1 cycle: in the cycle after capture, ser_valid=1 and ser_out=load_data[WIDTH-1].
REQ-015 SHIFT: load_ready=0 and ser_valid=1; a bit is consumed only when ser_valid && ser_ready at posedge clk; when ser_ready=0, ser_out and the bit count SHALL hold.
REQ-016 Bit order SHALL be load_data[WIDTH-1] down to load_data[0]; the bit counter counts 0..WIDTH-1 with no wrap past the final bit.
REQ-017 When the final data bit is consumed (and the parity bit, when enabled), the state SHALL go to DONE.
REQ-018 DONE SHALL last exactly 1 cycle with done=1, ser_valid=0, load_ready=0, then return to IDLE.
REQ-019 load_valid in SHIFT or DONE SHALL be ignored; the word in flight SHALL NOT be corrupted.
REQ-020 A new load SHALL be accepted no earlier than the first IDLE cycle after DONE; minimum word period is WIDTH+2 cycles (WIDTH+3 with parity).
REQ-021 ser_ready in IDLE or DONE SHALL have no effect.

Reset
REQ-022 rst==0 at posedge clk SHALL force IDLE, clear the shift register and bit counter, and set load_ready=1, ser_valid=0, ser_out=0, done=0 in the following cycle.
REQ-023 Reset SHALL take priority over all handshakes; reset during SHIFT SHALL abort the word, with no done pulse and no further bits.
REQ-024 Outputs SHALL be registered; no output SHALL depend combinationally on rst.

Configuration
REQ-025 Macro SERIAL_SHIFTER_TX_PARITY_EN, when defined, SHALL append one even-parity bit (XOR of all WIDTH data bits) after load_data[0], presented under the same ser_valid/ser_ready handshake.
REQ-026 Without SERIAL_SHIFTER_TX_PARITY_EN, exactly WIDTH bits SHALL be sent and no parity logic SHALL exist.

Structure
REQ-027 The FSM state typedef (IDLE/SHIFT/DONE) and the default WIDTH constant SHALL reside in shared package coa_pkg.
REQ-028 The bit counter SHALL be a sub-module bit_counter (clk, rst, clear, enable, count, last), using the same synchronous active-low reset.

Verification
REQ-029 WIDTH=8, load 8'hA5, ser_ready=1 constantly -> ser_out 1,0,1,0,0,1,0,1 on 8 consecutive cycles starting 1 cycle after load; done pulses 1 cycle later.
REQ-030 WIDTH=8, load 8'hF0, ser_ready toggling 1,0,1,0... -> each bit held while ser_ready=0; 8 bits in order 1,1,1,1,0,0,0,0; done after the 8th accepted bit.
REQ-031 Reset asserted (rst=0) after the 3rd bit of 8'h3C -> next cycle IDLE, load_ready=1, ser_valid=0, no done; a fresh load of 8'h81 sends 1,0,0,0,0,0,0,1 correctly.
REQ-032 load_valid held high with 8'h11 and then 8'h22 during SHIFT of 8'h11 -> 8'h22 is not accepted until the IDLE cycle after done; bit stream of 8'h11 is unchanged.
REQ-033 PARITY_EN defined, load 8'h07 -> 9 bits 0,0,0,0,0,1,1,1,1 (parity 1); load 8'h03 -> parity bit 0.
REQ-034 Back-to-back: load_valid held high with 8'h55 then 8'hAA -> gap between the last bit of 8'h55 and the first bit of 8'hAA is exactly 2 cycles (DONE, IDLE).
